// File: rtl/fetch_sequencer_if.sv
// Front-end fetch bus: control and ROM read port, plus the decode handshake.
interface fetch_sequencer_if;
    logic        start;
    logic [31:0] rom_size;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        done;

    // Environment side: drives control, ROM data and decode ready.
    modport master (
        output start, rom_size, rom_data, redirect_valid, redirect_pc, inst_ready,
        input  rom_en, rom_addr, inst_valid, inst_data, inst_pc, done
    );

    // Sequencer side.
    modport slave (
        input  start, rom_size, rom_data, redirect_valid, redirect_pc, inst_ready,
        output rom_en, rom_addr, inst_valid, inst_data, inst_pc, done
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one ROM read per cycle,
// absorbs the 1-cycle ROM latency and buffers returns in a 2-entry FIFO
// presented to decode over valid/ready.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          INSTR_BYTES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    fetch_sequencer_if.slave  bus
);

    localparam logic [32:0] STEP  = 33'(INSTR_BYTES);
    localparam logic [32:0] STEP2 = 33'(2 * INSTR_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_fifo_data [2];
    logic [31:0] r_fifo_pc   [2];
    logic        r_rd_ptr, r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_done;

    logic        w_issue, w_redirect, w_start, w_flush;
    logic        w_valid, w_pop, w_push, w_in_range, w_last;
    logic [31:0] w_redirect_tgt;

    // Redirect only matters while fetching; start only from IDLE/DONE.
    assign w_redirect     = bus.redirect_valid && (r_state == ST_RUN || r_state == ST_DRAIN);
    assign w_start        = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_flush        = w_redirect || w_start;
    assign w_redirect_tgt = bus.redirect_pc & ~32'h3;
    assign w_valid        = (r_count != 2'd0);
    assign w_pop          = w_valid && bus.inst_ready;
    // A return landing in a flush cycle belongs to the old path and is dropped.
    assign w_push         = r_inflight && !w_flush;
    // 33-bit compares so a PC near 2^32 can never wrap back into range.
    assign w_in_range     = ({1'b0, r_pc} + STEP)  <= {1'b0, bus.rom_size};
    assign w_last         = ({1'b0, r_pc} + STEP2) >  {1'b0, bus.rom_size};

    // Next-state, next-PC and issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (w_redirect) begin
                    w_pc_nxt = w_redirect_tgt;
                end else if (!w_in_range) begin
                    w_state_nxt = ST_DRAIN;
                end else if ((3'(r_count) + 3'(r_inflight) < 3'd2) || w_pop) begin
                    // Slot is guaranteed free by the time this read returns.
                    w_issue  = 1'b1;
                    w_pc_nxt = r_pc + 32'(INSTR_BYTES);
                    if (w_last) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_redirect) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = w_redirect_tgt;
                end else if (!r_inflight && r_count == 2'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = RESET_PC;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control state: FSM, PC, in-flight flag, FIFO pointers and done.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inflight <= w_issue;
            r_done     <= (w_state_nxt == ST_DONE);
            if (w_flush) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push) r_wr_ptr <= ~r_wr_ptr;
                if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
                r_count <= r_count + 2'(w_push) - 2'(w_pop);
            end
        end
    end

    // Datapath storage: issued PC tag and FIFO payload, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_issue) begin
            r_inflight_pc <= r_pc;
        end
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.rom_data;
            r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

    assign bus.rom_en     = w_issue;
    assign bus.rom_addr   = w_issue ? r_pc : 32'h0;
    assign bus.inst_valid = w_valid;
    assign bus.inst_data  = w_valid ? r_fifo_data[r_rd_ptr] : 32'h0;
    assign bus.inst_pc    = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios push expected {pc, data}
// into a scoreboard; a negedge monitor pops on every accepted instruction.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic reset;

    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_PC(32'h0), .INSTR_BYTES(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          en_cnt   = 0;
    int          base;
    logic [63:0] sb [$];
    logic        hold = 1'b0;
    logic [31:0] hold_pc, hold_data;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hC0DE_0000 + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Synchronous ROM: word appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr);
    end

    // Monitor: scoreboard pops, stall stability and ROM address legality.
    always @(negedge clk) begin
        logic [63:0] e;
        if (hold) begin
            chk("hold_valid", 32'(bus.inst_valid), 32'h1);
            chk("hold_pc", bus.inst_pc, hold_pc);
            chk("hold_data", bus.inst_data, hold_data);
        end
        if (!reset && bus.inst_valid && bus.inst_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got pc %h expected none", bus.inst_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", bus.inst_pc, e[63:32]);
                chk("pop_data", bus.inst_data, e[31:0]);
            end
        end
        if (bus.rom_en) begin
            en_cnt++;
            chk("rom_addr_legal",
                32'((({1'b0, bus.rom_addr} + 33'd4) <= {1'b0, bus.rom_size}) && (bus.rom_addr[1:0] == 2'b00)),
                32'h1);
        end
        hold      = !reset && bus.inst_valid && !bus.inst_ready && !bus.redirect_valid;
        hold_pc   = bus.inst_pc;
        hold_data = bus.inst_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int from, input int to_excl);
        for (int a = from; a < to_excl; a += 4) begin
            sb.push_back({32'(a), rom_word(32'(a))});
        end
    endtask

    // Pulse start; returns in the first cycle after start is sampled.
    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lim);
        for (int i = 0; i < lim && !bus.done; i++) tick();
        chk(name, 32'(bus.done), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.rom_size       = 32'd16;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b1;
        repeat (3) tick();
        chk("rst_rom_en",     32'(bus.rom_en), 32'h0);
        chk("rst_rom_addr",   bus.rom_addr, 32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_inst_data",  bus.inst_data, 32'h0);
        chk("rst_inst_pc",    bus.inst_pc, 32'h0);
        chk("rst_done",       32'(bus.done), 32'h0);
        reset = 1'b0;
        tick();

        // 1: streaming, 16-byte program.
        push_range(0, 16);
        base = en_cnt;
        do_start();
        chk("t1_first_en",   32'(bus.rom_en), 32'h1);
        chk("t1_first_addr", bus.rom_addr, 32'h0);
        tick();
        chk("t1_no_valid_yet", 32'(bus.inst_valid), 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t1_stream_valid", 32'(bus.inst_valid), 32'h1);
            chk("t1_stream_pc", bus.inst_pc, 32'(4 * k));
            tick();
        end
        wait_done("t1_done", 20);
        chk("t1_reads", 32'(en_cnt - base), 32'd4);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: decode stalls for several cycles after start.
        bus.inst_ready = 1'b0;
        push_range(0, 16);
        base = en_cnt;
        do_start();
        chk("t2_done_drop", 32'(bus.done), 32'h0);
        repeat (5) tick();
        chk("t2_stall_valid", 32'(bus.inst_valid), 32'h1);
        chk("t2_stall_pc", bus.inst_pc, 32'h0);
        chk("t2_outstanding", 32'(en_cnt - base), 32'd2);
        bus.inst_ready = 1'b1;
        wait_done("t2_done", 30);
        chk("t2_reads", 32'(en_cnt - base), 32'd4);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 5: empty / sub-word program.
        for (int s = 0; s < 4; s += 2) begin
            bus.rom_size = 32'(s);
            base = en_cnt;
            do_start();
            repeat (2) tick();
            chk("t5_done", 32'(bus.done), 32'h1);
            chk("t5_no_reads", 32'(en_cnt - base), 32'd0);
        end

        // 3: redirect with head pc 8 buffered and 12 in flight.
        bus.rom_size = 32'h80;
        push_range(0, 16);
        base = en_cnt;
        do_start();
        repeat (4) tick();
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        chk("t3_pre_valid", 32'(bus.inst_valid), 32'h1);
        chk("t3_pre_pc", bus.inst_pc, 32'h8);
        sb.delete();
        push_range(32'h40, 32'h80);
        tick();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        chk("t3_flushed", 32'(bus.inst_valid), 32'h0);
        wait_done("t3_done", 80);
        chk("t3_reads", 32'(en_cnt - base), 32'd20);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // 4a: redirect to an unaligned target on the last word.
        base = en_cnt;
        do_start();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h7E;
        push_range(32'h7C, 32'h80);
        tick();
        bus.redirect_valid = 1'b0;
        wait_done("t4a_done", 20);
        chk("t4a_reads", 32'(en_cnt - base), 32'd1);
        chk("t4a_sb_empty", 32'(sb.size()), 32'd0);

        // 4b: redirect beyond the program.
        base = en_cnt;
        do_start();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        wait_done("t4b_done", 20);
        chk("t4b_reads", 32'(en_cnt - base), 32'd0);

        // 6: reset with one entry buffered and one read in flight.
        bus.inst_ready = 1'b0;
        do_start();
        repeat (2) tick();
        chk("t6_pre_valid", 32'(bus.inst_valid), 32'h1);
        reset = 1'b1;
        tick();
        chk("t6_valid", 32'(bus.inst_valid), 32'h0);
        chk("t6_rom_en", 32'(bus.rom_en), 32'h0);
        chk("t6_done", 32'(bus.done), 32'h0);
        sb.delete();
        reset = 1'b0;
        tick();
        chk("t6_idle_valid", 32'(bus.inst_valid), 32'h0);
        chk("t6_idle_rom_en", 32'(bus.rom_en), 32'h0);
        bus.rom_size   = 32'd8;
        bus.inst_ready = 1'b1;
        push_range(0, 8);
        base = en_cnt;
        do_start();
        chk("t6_restart_en", 32'(bus.rom_en), 32'h1);
        chk("t6_restart_addr", bus.rom_addr, 32'h0);
        wait_done("t6_done_end", 20);
        chk("t6_reads", 32'(en_cnt - base), 32'd2);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
